// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the byte-wide RAM port arbiter.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA  = 2'd1,
    FETCH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic SIZE_BYTE  = 1'b1;
  localparam logic SIZE_WORD  = 1'b0;
  localparam logic RW_STORE   = 1'b1;
  localparam int   BEATS_WORD = 4;

  // Big-endian byte select: beat 0 carries bits [31:24], beat 3 carries [7:0].
  function automatic logic [7:0] beat_byte(input logic [31:0] word, input logic [1:0] beat);
    logic [7:0] b;
    case (beat)
      2'd0:    b = word[31:24];
      2'd1:    b = word[23:16];
      2'd2:    b = word[15:8];
      default: b = word[7:0];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/byte_beat_sequencer.sv
// Beat counter and byte-address generator for one RAM access.
module byte_beat_sequencer
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic              Clk,
  input  logic              Clr_n,
  input  logic              start,
  input  logic              advance,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              byte_mode,
  output logic [ADDR_W-1:0] addr,
  output logic [1:0]        beat,
  output logic              last
);

  logic [ADDR_W-1:0] base_q;
  logic [1:0]        beat_q;
  logic              byte_q;

  // Latch the access base on a grant, then step one beat per cycle.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      base_q <= '0;
      beat_q <= '0;
      byte_q <= 1'b0;
    end else if (start) begin
      base_q <= base_addr;
      beat_q <= '0;
      byte_q <= byte_mode;
    end else if (advance) begin
      beat_q <= beat_q + 2'd1;
    end
  end

  // Address wraps naturally at 2^ADDR_W.
  assign addr = base_q + ADDR_W'(beat_q);
  assign beat = beat_q;
  assign last = byte_q ? (beat_q == 2'd0) : (beat_q == 2'(BEATS_WORD - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the IF fetch port and MEM load/store port onto a byte-wide RAM.
//
// state | meaning
// IDLE  | no access; mem_req wins over if_req
// DATA  | beats for the MEM port
// FETCH | beats for the IF port
// DONE  | owner's done pulse; other port may be granted directly
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              Clr_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_done,
  input  logic              mem_req,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rw,
  input  logic              mem_size,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              mem_done,
  output logic              stall,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_we,
  input  logic [7:0]        ram_rdata
);

  state_t            state;
  logic              owner_mem_q;
  logic              rw_q;
  logic              size_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] asm_q;

  logic              grant_mem;
  logic              grant_if;
  logic              busy;
  logic              storing;
  logic [ADDR_W-1:0] seq_addr;
  logic [1:0]        seq_beat;
  logic              seq_last;

  // In DONE the port that just finished sits out one cycle so a held req is not re-accepted.
  assign grant_mem = mem_req && (state == IDLE || (state == DONE && !owner_mem_q));
  assign grant_if  = if_req && !grant_mem && (state == IDLE || (state == DONE && owner_mem_q));
  assign busy      = (state == DATA) || (state == FETCH);
  assign storing   = (state == DATA) && (rw_q == RW_STORE);

  byte_beat_sequencer #(.ADDR_W(ADDR_W)) u_seq (
    .Clk       (Clk),
    .Clr_n     (Clr_n),
    .start     (grant_mem | grant_if),
    .advance   (busy),
    .base_addr (grant_mem ? mem_addr : if_addr),
    .byte_mode (grant_mem && (mem_size == SIZE_BYTE)),
    .addr      (seq_addr),
    .beat      (seq_beat),
    .last      (seq_last)
  );

  // Access sequencing, request latching, data assembly and done pulses.
  always_ff @(posedge Clk or negedge Clr_n) begin
    if (!Clr_n) begin
      state       <= IDLE;
      owner_mem_q <= 1'b0;
      rw_q        <= 1'b0;
      size_q      <= SIZE_WORD;
      wdata_q     <= '0;
      asm_q       <= '0;
      if_rdata    <= '0;
      mem_rdata   <= '0;
      if_done     <= 1'b0;
      mem_done    <= 1'b0;
    end else begin
      if_done  <= 1'b0;
      mem_done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (grant_mem) begin
            state       <= DATA;
            owner_mem_q <= 1'b1;
            rw_q        <= mem_rw;
            size_q      <= mem_size;
            wdata_q     <= mem_wdata;
          end else if (grant_if) begin
            state       <= FETCH;
            owner_mem_q <= 1'b0;
          end else begin
            state <= IDLE;
          end
        end
        DATA: begin
          asm_q <= {asm_q[DATA_W-9:0], ram_rdata};
          if (seq_last) begin
            state    <= DONE;
            mem_done <= 1'b1;
            if (rw_q != RW_STORE) begin
              mem_rdata <= (size_q == SIZE_BYTE) ? {{(DATA_W-8){1'b0}}, ram_rdata}
                                                 : {asm_q[DATA_W-9:0], ram_rdata};
            end
          end
        end
        FETCH: begin
          asm_q <= {asm_q[DATA_W-9:0], ram_rdata};
          if (seq_last) begin
            state    <= DONE;
            if_done  <= 1'b1;
            if_rdata <= {asm_q[DATA_W-9:0], ram_rdata};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // RAM drive is gated by state so it drops to zero as soon as reset forces IDLE.
  assign ram_addr  = busy ? seq_addr : '0;
  assign ram_we    = storing;
  assign ram_wdata = storing ? ((size_q == SIZE_BYTE) ? wdata_q[7:0] : beat_byte(wdata_q[31:0], seq_beat))
                             : 8'h00;

  assign stall = (if_req & ~if_done) | (mem_req & ~mem_done);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a byte-wide RAM model.
module tb_mem_port_arbiter;

  logic        Clk = 1'b0;
  logic        Clr_n = 1'b0;
  logic        if_req = 1'b0;
  logic [7:0]  if_addr = '0;
  logic [31:0] if_rdata;
  logic        if_done;
  logic        mem_req = 1'b0;
  logic [7:0]  mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic        mem_rw = 1'b0;
  logic        mem_size = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_done;
  logic        stall;
  logic [7:0]  ram_addr;
  logic [7:0]  ram_wdata;
  logic        ram_we;
  logic [7:0]  ram_rdata;

  logic [7:0]  ram [256] = '{default: 8'h00};
  logic        pre_we = 1'b0;
  logic [7:0]  pre_addr = '0;
  logic [7:0]  pre_data = '0;

  int checks = 0;
  int failures = 0;
  int gap;

  mem_port_arbiter dut (
    .Clk       (Clk),
    .Clr_n     (Clr_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_done   (if_done),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rw    (mem_rw),
    .mem_size  (mem_size),
    .mem_rdata (mem_rdata),
    .mem_done  (mem_done),
    .stall     (stall),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_we    (ram_we),
    .ram_rdata (ram_rdata)
  );

  always #5 Clk = ~Clk;

  assign ram_rdata = ram[ram_addr];

  always @(posedge Clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    else if (pre_we) ram[pre_addr] <= pre_data;
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [7:0] a, input logic [7:0] d);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    step();
    pre_we = 1'b0;
  endtask

  initial begin
    // reset state
    #2;
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_mem_rdata", mem_rdata, 32'h0);
    chk("rst_done", {30'd0, if_done, mem_done}, 32'h0);
    chk("rst_ram_drive", {15'd0, ram_we, ram_addr, ram_wdata}, 32'h0);
    poke(8'h10, 8'hE3); poke(8'h11, 8'hA0); poke(8'h12, 8'h10); poke(8'h13, 8'h05);
    poke(8'h40, 8'h01); poke(8'h41, 8'h02); poke(8'h42, 8'h03); poke(8'h43, 8'h04);
    poke(8'h00, 8'hAA); poke(8'h01, 8'hBB); poke(8'h02, 8'hCC); poke(8'h03, 8'hDD);
    poke(8'hFE, 8'h12); poke(8'hFF, 8'h34);
    poke(8'h32, 8'h55); poke(8'h33, 8'h66);
    Clr_n = 1'b1;
    step();

    // word fetch
    if_req = 1'b1; if_addr = 8'h10;
    #1;
    chk("fetch_stall_c0", stall, 1);
    for (int k = 0; k < 4; k++) begin
      step();
      chk("fetch_addr", ram_addr, 8'h10 + k);
      chk("fetch_stall", stall, 1);
      chk("fetch_we", ram_we, 0);
    end
    step();
    chk("fetch_done", if_done, 1);
    chk("fetch_rdata", if_rdata, 32'hE3A01005);
    chk("fetch_stall_c5", stall, 0);
    if_req = 1'b0;
    step();
    chk("fetch_done_pulse", if_done, 0);

    // simultaneous requests: data first, then fetch from DONE
    mem_req = 1'b1; mem_addr = 8'h40; mem_rw = 1'b0; mem_size = 1'b0;
    if_req = 1'b1; if_addr = 8'h00;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sim_data_addr", ram_addr, 8'h40 + k);
      chk("sim_stall", stall, 1);
    end
    step();
    chk("sim_mem_done", mem_done, 1);
    chk("sim_mem_rdata", mem_rdata, 32'h01020304);
    chk("sim_if_not_done", if_done, 0);
    chk("sim_stall_c5", stall, 1);
    mem_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("sim_fetch_addr", ram_addr, 8'h00 + k);
      chk("sim_stall_f", stall, 1);
    end
    step();
    chk("sim_if_done", if_done, 1);
    chk("sim_if_rdata", if_rdata, 32'hAABBCCDD);
    if_req = 1'b0;
    step();

    // byte store then byte load
    mem_req = 1'b1; mem_addr = 8'h20; mem_rw = 1'b1; mem_size = 1'b1; mem_wdata = 32'hAABBCC44;
    step();
    chk("bst_we", ram_we, 1);
    chk("bst_wdata", ram_wdata, 8'h44);
    chk("bst_addr", ram_addr, 8'h20);
    step();
    chk("bst_done", mem_done, 1);
    chk("bst_rdata_kept", mem_rdata, 32'h01020304);
    chk("bst_ram20", ram[8'h20], 8'h44);
    chk("bst_ram21", ram[8'h21], 8'h00);
    mem_req = 1'b0;
    step();
    mem_req = 1'b1; mem_rw = 1'b0; mem_size = 1'b1;
    step();
    chk("bld_addr", ram_addr, 8'h20);
    step();
    chk("bld_done", mem_done, 1);
    chk("bld_rdata", mem_rdata, 32'h00000044);
    mem_req = 1'b0;
    step();

    // address wrap
    mem_req = 1'b1; mem_addr = 8'hFE; mem_rw = 1'b0; mem_size = 1'b0;
    step(); chk("wrap_a0", ram_addr, 8'hFE);
    step(); chk("wrap_a1", ram_addr, 8'hFF);
    step(); chk("wrap_a2", ram_addr, 8'h00);
    step(); chk("wrap_a3", ram_addr, 8'h01);
    step();
    chk("wrap_done", mem_done, 1);
    chk("wrap_rdata", mem_rdata, 32'h1234AABB);
    mem_req = 1'b0;
    step();

    // reset in the middle of a word store
    mem_req = 1'b1; mem_addr = 8'h30; mem_rw = 1'b1; mem_size = 1'b0; mem_wdata = 32'h11223344;
    step();
    chk("rst_st_b0", ram_wdata, 8'h11);
    step();
    chk("rst_st_b1", ram_wdata, 8'h22);
    step();
    Clr_n = 1'b0;
    mem_req = 1'b0;
    #1;
    chk("rst_mid_drive", {15'd0, ram_we, ram_addr, ram_wdata}, 32'h0);
    chk("rst_mid_rdata", mem_rdata, 32'h0);
    chk("rst_mid_if_rdata", if_rdata, 32'h0);
    chk("rst_mid_done", {30'd0, if_done, mem_done}, 32'h0);
    step();
    chk("rst_ram30", ram[8'h30], 8'h11);
    chk("rst_ram31", ram[8'h31], 8'h22);
    chk("rst_ram32", ram[8'h32], 8'h55);
    chk("rst_ram33", ram[8'h33], 8'h66);
    Clr_n = 1'b1;
    if_req = 1'b1; if_addr = 8'h10;
    for (int k = 0; k < 5; k++) step();
    chk("post_rst_done", if_done, 1);
    chk("post_rst_rdata", if_rdata, 32'hE3A01005);

    // held req at done: ignored in the done cycle, next done 6 cycles later
    step();
    chk("held_idle_done", if_done, 0);
    chk("held_idle_addr", ram_addr, 8'h00);
    chk("held_idle_stall", stall, 1);
    gap = 1;
    while (!if_done && gap < 12) begin
      step();
      gap++;
    end
    chk("held_gap", gap, 6);
    chk("held_rdata", if_rdata, 32'hE3A01005);
    if_req = 1'b0;
    step();
    chk("held_quiet", {30'd0, if_done, stall}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
